seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Three-digit multiplexed display scanner: digit 2 -> 1 -> 0, each slot opens with a
// blanking window so the digit selector settles before its anode is driven.
module seg_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       LZS,
    input  logic [3:0] CNT,
    output logic [1:0] SW,
    output logic [2:0] AN,
    output logic       SLOT_TICK,
    output logic       FRAME_TICK
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] BLANK_LAST = PS_W'(BLANK - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BLANKING = 2'd1;
    localparam logic [1:0] DRIVE    = 2'd2;

    localparam logic [1:0] DIG2 = 2'b10;
    localparam logic [1:0] DIG1 = 2'b01;
    localparam logic [1:0] DIG0 = 2'b00;

    logic [1:0]      state;
    logic [PS_W-1:0] ps_cnt;
    logic            run;
    logic            zero;
    logic [1:0]      next_dig;

    // Leading-zero suppression applies only to digits 2 and 1 while no nonzero digit has been seen.
    function automatic logic [2:0] drive_an(input logic [1:0] dig, input logic lzs,
                                            input logic run_f, input logic zero_f);
        logic [2:0] a;
        case (dig)
            DIG2:    a = 3'b011;
            DIG1:    a = 3'b101;
            default: a = 3'b110;
        endcase
        if (dig != DIG0 && lzs && run_f && zero_f)
            a = 3'b111;
        return a;
    endfunction

    always_comb begin
        case (SW)
            DIG2:    next_dig = DIG1;
            DIG1:    next_dig = DIG0;
            default: next_dig = DIG2;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            ps_cnt     <= '0;
            run        <= 1'b1;
            zero       <= 1'b0;
            SW         <= DIG2;
            AN         <= 3'b111;
            SLOT_TICK  <= 1'b0;
            FRAME_TICK <= 1'b0;
        end else if (!EN) begin
            // Disable wins over any slot boundary in the same cycle.
            state      <= IDLE;
            ps_cnt     <= '0;
            SW         <= DIG2;
            AN         <= 3'b111;
            SLOT_TICK  <= 1'b0;
            FRAME_TICK <= 1'b0;
        end else begin
            SLOT_TICK  <= 1'b0;
            FRAME_TICK <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= BLANKING;
                    ps_cnt     <= '0;
                    SW         <= DIG2;
                    AN         <= 3'b111;
                    run        <= 1'b1;
                    SLOT_TICK  <= 1'b1;
                    FRAME_TICK <= 1'b1;
                end
                BLANKING: begin
                    ps_cnt <= ps_cnt + PS_W'(1);
                    AN     <= 3'b111;
                    if (ps_cnt == BLANK_LAST) begin
                        // CNT has had the whole blanking window to settle for this SW.
                        zero  <= (CNT == 4'd0);
                        state <= DRIVE;
                        AN    <= drive_an(SW, LZS, run, CNT == 4'd0);
                    end
                end
                DRIVE: begin
                    if (ps_cnt == PS_LAST) begin
                        ps_cnt     <= '0;
                        SW         <= next_dig;
                        state      <= BLANKING;
                        AN         <= 3'b111;
                        SLOT_TICK  <= 1'b1;
                        FRAME_TICK <= (next_dig == DIG2);
                        if (next_dig == DIG2)
                            run <= 1'b1;
                        else if (!zero)
                            run <= 1'b0;
                    end else begin
                        ps_cnt <= ps_cnt + PS_W'(1);
                        AN     <= drive_an(SW, LZS, run, zero);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=8, BLANK=2 and a per-digit CNT model.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, lzs;
    logic [3:0] cnt, c3, c2, c1;
    logic [1:0] sw;
    logic [2:0] an;
    logic       slot_tick, frame_tick;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Digit selector model: returns the value for whichever digit SW points at.
    assign cnt = (sw == 2'b10) ? c3 : (sw == 2'b01) ? c2 : c1;

    seg_scan_ctrl #(.PRESCALE(8), .BLANK(2)) dut (
        .CLK(clk), .RST(rst), .EN(en), .LZS(lzs), .CNT(cnt),
        .SW(sw), .AN(an), .SLOT_TICK(slot_tick), .FRAME_TICK(frame_tick)
    );

    typedef struct {
        logic       lzs;
        logic [3:0] c3, c2, c1;
        logic [2:0] an2, an1, an0;
    } vec_t;

    vec_t       vecs[5];
    logic [1:0] sw_of[3];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_out(input string tag, input logic [1:0] esw, input logic [2:0] ean,
                              input logic es, input logic ef);
        checks++;
        if ({sw, an, slot_tick, frame_tick} !== {esw, ean, es, ef}) begin
            errors++;
            $display("FAIL %s: got sw=%b an=%b slot=%b frame=%b, want sw=%b an=%b slot=%b frame=%b",
                     tag, sw, an, slot_tick, frame_tick, esw, ean, es, ef);
        end
    endtask

    // Reset with EN high, then release: the first free edge is the IDLE exit, leaving
    // the bench at cycle 0 of the digit-2 slot.
    task automatic restart(input logic l, input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1);
        rst = 1'b1; en = 1'b1; lzs = l; c3 = d3; c2 = d2; c1 = d1;
        step();
        expect_out("reset_en_high", 2'b10, 3'b111, 1'b0, 1'b0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; lzs = 1'b0; c3 = '0; c2 = '0; c1 = '0;
        sw_of[0] = 2'b10; sw_of[1] = 2'b01; sw_of[2] = 2'b00;

        vecs[0] = '{lzs: 1'b0, c3: 4'd3, c2: 4'd12, c1: 4'd10, an2: 3'b011, an1: 3'b101, an0: 3'b110};
        vecs[1] = '{lzs: 1'b1, c3: 4'd0, c2: 4'd0,  c1: 4'd0,  an2: 3'b111, an1: 3'b111, an0: 3'b110};
        vecs[2] = '{lzs: 1'b1, c3: 4'd0, c2: 4'd5,  c1: 4'd0,  an2: 3'b111, an1: 3'b101, an0: 3'b110};
        vecs[3] = '{lzs: 1'b1, c3: 4'd3, c2: 4'd0,  c1: 4'd0,  an2: 3'b011, an1: 3'b101, an0: 3'b110};
        vecs[4] = '{lzs: 1'b0, c3: 4'd0, c2: 4'd0,  c1: 4'd0,  an2: 3'b011, an1: 3'b101, an0: 3'b110};

        @(negedge clk);
        step();
        expect_out("reset_state", 2'b10, 3'b111, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_out("idle_en_low", 2'b10, 3'b111, 1'b0, 1'b0);

        // Two full frames per vector: slot cycles 0..1 blank, 2..7 drive.
        for (int v = 0; v < 5; v++) begin
            restart(vecs[v].lzs, vecs[v].c3, vecs[v].c2, vecs[v].c1);
            for (int f = 0; f < 2; f++) begin
                for (int s = 0; s < 3; s++) begin
                    for (int c = 0; c < 8; c++) begin
                        logic [2:0] ean;
                        ean = (s == 0) ? vecs[v].an2 : (s == 1) ? vecs[v].an1 : vecs[v].an0;
                        if (c < 2) ean = 3'b111;
                        expect_out($sformatf("vec%0d_f%0d_s%0d_c%0d", v, f, s, c),
                                   sw_of[s], ean, c == 0, (c == 0) && (s == 0));
                        step();
                    end
                end
            end
        end

        // EN dropped at ps_cnt=5 of digit 1, re-asserted one cycle later.
        restart(1'b0, 4'd3, 4'd12, 4'd10);
        steps(13);
        expect_out("en_drop_pre", 2'b01, 3'b101, 1'b0, 1'b0);
        en = 1'b0;
        step();
        expect_out("en_drop_dark", 2'b10, 3'b111, 1'b0, 1'b0);
        en = 1'b1;
        step();
        expect_out("en_reassert_tick", 2'b10, 3'b111, 1'b1, 1'b1);
        steps(2);
        expect_out("en_reassert_drive", 2'b10, 3'b011, 1'b0, 1'b0);

        // EN dropped on the last cycle of a slot: disable beats the slot boundary.
        restart(1'b0, 4'd3, 4'd12, 4'd10);
        steps(15);
        expect_out("slot_end_pre", 2'b01, 3'b101, 1'b0, 1'b0);
        en = 1'b0;
        step();
        expect_out("en_beats_slot_end", 2'b10, 3'b111, 1'b0, 1'b0);
        en = 1'b1;
        step();
        expect_out("slot_end_restart", 2'b10, 3'b111, 1'b1, 1'b1);

        // One-cycle reset mid-DRIVE of digit 0.
        restart(1'b0, 4'd3, 4'd12, 4'd10);
        steps(20);
        expect_out("mid_rst_pre", 2'b00, 3'b110, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        expect_out("mid_rst_dark", 2'b10, 3'b111, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_out("mid_rst_restart", 2'b10, 3'b111, 1'b1, 1'b1);
        steps(2);
        expect_out("mid_rst_drive", 2'b10, 3'b011, 1'b0, 1'b0);

        // LZS raised mid-DRIVE over a zero digit 2 blanks it from the next cycle.
        restart(1'b0, 4'd0, 4'd0, 4'd0);
        steps(4);
        expect_out("lzs_pre", 2'b10, 3'b011, 1'b0, 1'b0);
        lzs = 1'b1;
        step();
        expect_out("lzs_apply", 2'b10, 3'b111, 1'b0, 1'b0);
        steps(5);
        expect_out("lzs_digit1", 2'b01, 3'b111, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
